// File: rtl/ofs_plat_avalon_burst_wrr_arb.sv
// rtl/ofs_plat_avalon_burst_wrr_arb.sv - burst-aware weighted round-robin arbiter for a shared Avalon request channel
//
// Purpose:
//   Shares one Avalon request path among NUM_CLIENTS request FIFOs.
//   - Each client may win up to weight[i] consecutive bursts per turn.
//   - A granted multi-flit burst locks the grant to its client until the last flit.
//
// Ports:
//   clk, reset_n    clock and synchronous active-low reset
//   ena             sink can accept a flit this cycle
//   request         per-client "flit at FIFO head"
//   req_burstcount  per-client head-flit burstcount, packed BURST_CNT_WIDTH per client
//   weight          per-client bursts per turn, packed WEIGHT_WIDTH per client
//   grant           one-hot, combinational: client's flit is consumed this cycle
//   grantIdx        index of the granted or locked client
//   sop             next granted flit starts a burst
//   eop             flit granted this cycle ends its burst
module ofs_plat_avalon_burst_wrr_arb #(
    parameter int NUM_CLIENTS     = 4,
    parameter int BURST_CNT_WIDTH = 7,
    parameter int WEIGHT_WIDTH    = 4,
    localparam int IDX_W          = $clog2(NUM_CLIENTS)
) (
    input  logic                                   clk,
    input  logic                                   reset_n,
    input  logic                                   ena,
    input  logic [NUM_CLIENTS-1:0]                 request,
    input  logic [NUM_CLIENTS*BURST_CNT_WIDTH-1:0] req_burstcount,
    input  logic [NUM_CLIENTS*WEIGHT_WIDTH-1:0]    weight,
    output logic [NUM_CLIENTS-1:0]                 grant,
    output logic [IDX_W-1:0]                       grantIdx,
    output logic                                   sop,
    output logic                                   eop
);

    logic [IDX_W-1:0]           last_idx_q, last_idx_d;
    logic [WEIGHT_WIDTH-1:0]    quota_q, quota_d;
    logic [BURST_CNT_WIDTH-1:0] flits_left_q, flits_left_d;
    logic                       in_burst_q, in_burst_d;

    logic [IDX_W-1:0]           scan_idx;
    logic                       scan_found;
    logic                       keep_last;
    logic [IDX_W-1:0]           winner;
    logic [BURST_CNT_WIDTH-1:0] win_bc;
    logic [BURST_CNT_WIDTH-1:0] win_bc_eff;
    logic [WEIGHT_WIDTH-1:0]    win_w;
    logic [WEIGHT_WIDTH-1:0]    quota_load;
    logic                       arb_go;
    logic                       lock_go;

    // Round-robin scan starting just after the last winner. The final
    // candidate is last_idx itself, so a lone requester whose quota ran out
    // still wins and gets a fresh quota.
    always_comb begin
        int unsigned cand;
        scan_idx   = last_idx_q;
        scan_found = 1'b0;
        cand       = 0;
        for (int k = 1; k <= NUM_CLIENTS; k++) begin
            cand = (int'(last_idx_q) + k) % NUM_CLIENTS;
            if (!scan_found && request[cand]) begin
                scan_found = 1'b1;
                scan_idx   = IDX_W'(cand);
            end
        end
    end

    always_comb begin
        keep_last  = request[last_idx_q] && (quota_q != '0);
        winner     = keep_last ? last_idx_q : scan_idx;
        win_bc     = req_burstcount[winner*BURST_CNT_WIDTH +: BURST_CNT_WIDTH];
        win_bc_eff = (win_bc == '0) ? BURST_CNT_WIDTH'(1) : win_bc;
        win_w      = weight[winner*WEIGHT_WIDTH +: WEIGHT_WIDTH];
        // Effective weight treats 0 as 1; quota holds the bursts remaining after this one.
        quota_load = (win_w == '0) ? '0 : win_w - WEIGHT_WIDTH'(1);

        arb_go  = !in_burst_q && ena && (|request);
        // While locked, only the locked client can move; other requests are ignored.
        lock_go = in_burst_q && ena && request[last_idx_q];
    end

    always_comb begin
        grant = '0;
        if (arb_go) begin
            grant[winner] = 1'b1;
        end else if (lock_go) begin
            grant[last_idx_q] = 1'b1;
        end
        grantIdx = arb_go ? winner : last_idx_q;
        sop      = !in_burst_q;
        eop      = arb_go ? (win_bc_eff == BURST_CNT_WIDTH'(1))
                          : (lock_go && (flits_left_q == BURST_CNT_WIDTH'(1)));
    end

    always_comb begin
        last_idx_d   = last_idx_q;
        quota_d      = quota_q;
        flits_left_d = flits_left_q;
        in_burst_d   = in_burst_q;
        if (arb_go) begin
            last_idx_d = winner;
            quota_d    = keep_last ? quota_q - WEIGHT_WIDTH'(1) : quota_load;
            if (win_bc_eff > BURST_CNT_WIDTH'(1)) begin
                in_burst_d   = 1'b1;
                flits_left_d = win_bc_eff - BURST_CNT_WIDTH'(1);
            end else begin
                flits_left_d = '0;
            end
        end else if (lock_go) begin
            flits_left_d = flits_left_q - BURST_CNT_WIDTH'(1);
            if (flits_left_q == BURST_CNT_WIDTH'(1)) begin
                in_burst_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            // Client 0 wins first after reset.
            last_idx_q   <= IDX_W'(NUM_CLIENTS - 1);
            quota_q      <= '0;
            flits_left_q <= '0;
            in_burst_q   <= 1'b0;
        end else begin
            last_idx_q   <= last_idx_d;
            quota_q      <= quota_d;
            flits_left_q <= flits_left_d;
            in_burst_q   <= in_burst_d;
        end
    end

endmodule
